// File: rtl/fft_stage_seq.sv
// Beat/frame sequencer for a 16-lane FFT butterfly stage: tracks beat index and twiddle
// address, aligns valid/sof/eof with the butterfly output and counts completed frames.
module fft_stage_seq #(
    parameter int BEATS   = 32,
    parameter int BEAT_W  = 5,
    parameter int LATENCY = 5,
    parameter int FCNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic              clr_err,
    output logic [BEAT_W-1:0] beat_idx,
    output logic [BEAT_W-1:0] tw_addr,
    output logic              bfly_en,
    output logic              dout_valid,
    output logic              sof_out,
    output logic              eof_out,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              err_gap,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [BEAT_W-1:0] count, count_nxt;
    logic              gap;
    logic              pipe_busy;

    logic [LATENCY-1:0] vld_pipe;
    logic [LATENCY-1:0] sof_pipe;
    logic [LATENCY-1:0] eof_pipe;

    assign pipe_busy = |vld_pipe;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        gap       = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    state_nxt = RUN;
                    count_nxt = BEAT_W'(1);
                end
            end
            RUN: begin
                if (din_valid) begin
                    if (count == BEAT_W'(BEATS - 1)) begin
                        state_nxt = DRAIN;
                        count_nxt = '0;
                    end else begin
                        count_nxt = count + BEAT_W'(1);
                    end
                end else begin
                    // Missing beat mid-frame: abandon the frame, let accepted beats drain.
                    gap       = 1'b1;
                    state_nxt = DRAIN;
                    count_nxt = '0;
                end
            end
            DRAIN: begin
                if (din_valid) begin
                    state_nxt = RUN;
                    count_nxt = BEAT_W'(1);
                end else if (!pipe_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    assign beat_idx = (state == RUN) ? count : '0;
    assign tw_addr  = beat_idx;

    // Stage 0 captures the accepted beat; stage LATENCY-1 is the stage output.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            sof_pipe <= '0;
            eof_pipe <= '0;
        end else begin
            vld_pipe[0] <= din_valid;
            sof_pipe[0] <= din_valid & (beat_idx == '0);
            eof_pipe[0] <= din_valid & (beat_idx == BEAT_W'(BEATS - 1));
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                sof_pipe[i] <= sof_pipe[i-1];
                eof_pipe[i] <= eof_pipe[i-1];
            end
        end
    end

    assign dout_valid = vld_pipe[LATENCY-1];
    assign sof_out    = sof_pipe[LATENCY-1];
    assign eof_out    = eof_pipe[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (dout_valid && eof_out) begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_gap <= 1'b0;
        end else if (gap) begin
            err_gap <= 1'b1;
        end else if (clr_err) begin
            err_gap <= 1'b0;
        end
    end

    assign bfly_en = din_valid | pipe_busy;
    assign busy    = (state == RUN) | pipe_busy;

endmodule

// File: tb/tb_fft_stage_seq.sv
// Self-checking bench for fft_stage_seq: frame-level reference model compared every cycle,
// plus directed frames with hand-derived timing points.
module tb_fft_stage_seq;

    localparam int BEATS   = 32;
    localparam int BEAT_W  = 5;
    localparam int LATENCY = 5;
    localparam int FCNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              din_valid = 1'b0;
    logic              clr_err = 1'b0;
    logic [BEAT_W-1:0] beat_idx;
    logic [BEAT_W-1:0] tw_addr;
    logic              bfly_en;
    logic              dout_valid;
    logic              sof_out;
    logic              eof_out;
    logic [FCNT_W-1:0] frame_cnt;
    logic              err_gap;
    logic              busy;

    fft_stage_seq #(
        .BEATS(BEATS), .BEAT_W(BEAT_W), .LATENCY(LATENCY), .FCNT_W(FCNT_W)
    ) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .clr_err(clr_err),
        .beat_idx(beat_idx), .tw_addr(tw_addr), .bfly_en(bfly_en),
        .dout_valid(dout_valid), .sof_out(sof_out), .eof_out(eof_out),
        .frame_cnt(frame_cnt), .err_gap(err_gap), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc  = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, ncyc, act, exp);
        end
    endtask

    // Reference model: beats accepted so far in the current frame, plus a list of
    // accepted beats with the cycle their output must appear.
    typedef struct { int t; bit sof; bit eof; } ev_t;
    ev_t q[$];
    bit  m_in_frame = 0;
    int  m_pos      = 0;
    int  m_frames   = 0;
    bit  m_err      = 0;
    bit  e_v, e_s, e_e, m_gap;
    int  m_beat;

    always @(negedge clk) begin
        e_v = 0; e_s = 0; e_e = 0;
        if (q.size() > 0 && q[0].t == ncyc) begin
            e_v = 1; e_s = q[0].sof; e_e = q[0].eof;
        end
        if (chk_en) begin
            chk("dout_valid", dout_valid, e_v);
            chk("sof_out", sof_out, e_s);
            chk("eof_out", eof_out, e_e);
            chk("frame_cnt", frame_cnt, m_frames);
            chk("err_gap", err_gap, m_err);
            chk("busy", busy, m_in_frame || (q.size() > 0));
            chk("bfly_en", bfly_en, din_valid || (q.size() > 0));
            if (din_valid) begin
                chk("beat_idx", beat_idx, m_in_frame ? m_pos : 0);
                chk("tw_addr", tw_addr, m_in_frame ? m_pos : 0);
            end
        end
        if (e_v) begin
            void'(q.pop_front());
            if (e_e) m_frames = (m_frames + 1) % (1 << FCNT_W);
        end
        if (rst) begin
            q.delete();
            m_in_frame = 0; m_pos = 0; m_frames = 0; m_err = 0;
        end else begin
            m_gap = m_in_frame && !din_valid;
            if (din_valid) begin
                m_beat = m_in_frame ? m_pos : 0;
                q.push_back('{t: ncyc + LATENCY, sof: (m_beat == 0), eof: (m_beat == BEATS - 1)});
                m_pos      = m_beat + 1;
                m_in_frame = (m_pos < BEATS);
                if (!m_in_frame) m_pos = 0;
            end else begin
                m_in_frame = 0;
                m_pos      = 0;
            end
            if (m_gap) m_err = 1;
            else if (clr_err) m_err = 0;
        end
        ncyc++;
    end

    // Drive one cycle's inputs shortly after the rising edge, return at the falling edge.
    task automatic tick(input logic v, input logic c, input logic r);
        @(posedge clk);
        #1;
        din_valid = v;
        clr_err   = c;
        rst       = r;
        @(negedge clk);
        #1;
    endtask

    // A single clean frame from idle: first output 5 cycles after beat 0, last at 36.
    task automatic single_frame;
        int fc0;
        fc0 = int'(frame_cnt);
        for (int k = 0; k < 40; k++) begin
            tick(k < BEATS, 1'b0, 1'b0);
            if (k == 4)  chk("t1_no_out_early", dout_valid, 0);
            if (k == 5)  chk("t1_first_out", {dout_valid, sof_out}, 2'b11);
            if (k == 36) chk("t1_last_out", {dout_valid, eof_out}, 2'b11);
            if (k == 36) chk("t1_cnt_before", frame_cnt, fc0);
            if (k == 37) chk("t1_cnt_after", frame_cnt, (fc0 + 1) % 256);
            if (k == 37) chk("t1_busy_low", busy, 0);
        end
    endtask

    int nv, ns, ne, fc0;

    initial begin
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        chk_en = 1;
        tick(1'b0, 1'b0, 1'b0);
        chk("reset_outputs",
            {dout_valid, sof_out, eof_out, err_gap, busy, bfly_en, frame_cnt, beat_idx, tw_addr},
            0);

        single_frame();

        // Back-to-back frames
        nv = 0; ns = 0; ne = 0; fc0 = int'(frame_cnt);
        for (int k = 0; k < 72; k++) begin
            tick(k < 2 * BEATS, 1'b0, 1'b0);
            nv += int'(dout_valid); ns += int'(sof_out); ne += int'(eof_out);
            if (k == 5 + 32) chk("t2_sof2", {dout_valid, sof_out}, 2'b11);
            if (k == 5 + 63) chk("t2_eof2", {dout_valid, eof_out}, 2'b11);
        end
        chk("t2_nvalid", nv, 64);
        chk("t2_nsof", ns, 2);
        chk("t2_neof", ne, 2);
        chk("t2_frames", frame_cnt, fc0 + 2);
        chk("t2_err", err_gap, 0);

        // Gap at beat 10
        nv = 0; ns = 0; ne = 0; fc0 = int'(frame_cnt);
        for (int k = 0; k < 21; k++) begin
            tick(k < 10, 1'b0, 1'b0);
            nv += int'(dout_valid); ns += int'(sof_out); ne += int'(eof_out);
            if (k == 10) chk("t3_err_not_yet", err_gap, 0);
            if (k == 11) chk("t3_err_set", err_gap, 1);
        end
        chk("t3_nvalid", nv, 10);
        chk("t3_nsof", ns, 1);
        chk("t3_neof", ne, 0);
        chk("t3_frames", frame_cnt, fc0);
        tick(1'b1, 1'b0, 1'b0);
        chk("t3_restart_idx", beat_idx, 0);
        for (int k = 1; k < BEATS + 8; k++) tick(k < BEATS, 1'b0, 1'b0);
        chk("t3_frames_after", frame_cnt, fc0 + 1);

        // Sticky error and clear
        for (int k = 0; k < 100; k++) tick(1'b0, 1'b0, 1'b0);
        chk("t4_sticky", err_gap, 1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("t4_cleared", err_gap, 0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("t4_set_wins", err_gap, 1);
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        // Reset mid-frame
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk("t5_reset_outputs",
            {dout_valid, sof_out, eof_out, err_gap, busy, bfly_en, frame_cnt, beat_idx, tw_addr},
            0);
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            nv += int'(dout_valid);
        end
        chk("t5_no_valid", nv, 0);
        single_frame();

        // Frame counter wrap from reset
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < BEATS; k++) tick(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick(1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b0);
        chk("t6_wrap", frame_cnt, 0);
        chk("t6_err", err_gap, 0);

        // Random traffic with occasional gaps, clears and resets
        for (int k = 0; k < 2000; k++) begin
            tick(($urandom_range(0, 15) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 127) == 0));
        end
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
